// File: rtl/spi_sched_pkg.sv
// rtl/spi_sched_pkg.sv - shared state encoding and frame sizing for spi_resp_sched
// Frame length grows by one parity bit when SPI_SCHED_PARITY_EN is defined.
package spi_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

`ifdef SPI_SCHED_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Wide enough for any frame up to 255 bits.
  localparam int CNT_W = 8;

  function automatic int frame_len(input int idw, input int dw);
    return 1 + idw + dw + PARITY_BITS;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - 2-FF history on an asynchronous pin with rise/fall pulses
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  // hist[1] is the older sample, hist[0] the newer one.
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) hist <= 2'b00;
    else     hist <= {hist[0], din};
  end

  assign rise = (hist == 2'b01);
  assign fall = (hist == 2'b10);

endmodule

// File: rtl/spi_resp_sched.sv
// rtl/spi_resp_sched.sv - SPI-slave response scheduler, round-robin grant per SSEL frame
// Optional trailing even-parity bit with SPI_SCHED_PARITY_EN.
module spi_resp_sched
  import spi_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SSEL,
  input  logic             SCK,
  input  logic             MOSI,
  inout  wire              MISO,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ack
);

  localparam int FRAME = frame_len(IDW, DW);

  logic ssel_rise, ssel_fall, sck_rise, sck_fall;

  spi_edge_sync u_ssel_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (SSEL),
    .rise (ssel_rise),
    .fall (ssel_fall)
  );

  spi_edge_sync u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (SCK),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  state_t           state;
  logic [FRAME-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             commit;
  logic [IDW-1:0]   grant;
  logic             grant_v;
  logic             miso_q;
  logic             oe;
  logic             fall_pend;
  logic [IDW-1:0]   rr_ptr;

  logic             pick_v;
  logic [IDW-1:0]   pick_id;
  logic [DW-1:0]    pick_data;
  logic [FRAME-1:0] frame_word;
  int               idx;

  // Descending scan so the requester closest to rr_ptr is the last (winning) hit.
  always_comb begin
    pick_v  = 1'b0;
    pick_id = '0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        pick_v  = 1'b1;
        pick_id = IDW'(idx);
      end
    end
    pick_data = pick_v ? req_data[int'(pick_id)*DW +: DW] : '0;
`ifdef SPI_SCHED_PARITY_EN
    frame_word = {pick_v, pick_id, pick_data, ^{pick_id, pick_data}};
`else
    frame_word = {pick_v, pick_id, pick_data};
`endif
  end

  assign MISO = oe ? miso_q : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      commit    <= 1'b0;
      grant     <= '0;
      grant_v   <= 1'b0;
      miso_q    <= 1'b0;
      oe        <= 1'b0;
      fall_pend <= 1'b0;
      rr_ptr    <= '0;
      req_ack   <= '0;
    end else begin
      req_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (ssel_fall || fall_pend) begin
            fall_pend <= 1'b0;
            grant     <= pick_id;
            grant_v   <= pick_v;
            miso_q    <= frame_word[FRAME-1];
            shreg     <= {frame_word[FRAME-2:0], 1'b0};
            bit_cnt   <= '0;
            commit    <= 1'b0;
            oe        <= 1'b1;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ssel_rise) begin
            oe    <= 1'b0;
            state <= ST_FINISH;
          end else begin
            // Zero fill keeps MISO low once the whole frame has gone out.
            if (sck_fall) begin
              miso_q <= shreg[FRAME-1];
              shreg  <= {shreg[FRAME-2:0], 1'b0};
              if (bit_cnt != CNT_W'(FRAME)) bit_cnt <= bit_cnt + 1'b1;
            end
            if (sck_rise && bit_cnt == '0) commit <= MOSI;
          end
        end
        ST_FINISH: begin
          if (ssel_fall) fall_pend <= 1'b1;
          if (grant_v && commit && bit_cnt == CNT_W'(FRAME) && req_valid[grant]) begin
            req_ack <= NREQ'(1) << grant;
            rr_ptr  <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_resp_sched.sv
// tb/tb_spi_resp_sched.sv - table-driven frame vectors plus mid-frame reset sequence
module tb_spi_resp_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SSEL = 1'b1;
  logic        SCK = 1'b0;
  logic        MOSI = 1'b0;
  wire         MISO;
  logic [3:0]  req_valid = 4'b0000;
  logic [31:0] req_data;
  logic [3:0]  req_ack;

  // Released MISO reads as 1, which makes the tri-state visible to the checks.
  pullup (MISO);

  spi_resp_sched #(.NREQ(4), .DW(8), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .SSEL      (SSEL),
    .SCK       (SCK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] BASE_DATA = {8'h3C, 8'h5A, 8'hA5, 8'h96};
  localparam logic [10:0] F_ID0  = 11'b1_00_10010110;
  localparam logic [10:0] F_ID1  = 11'b1_01_10100101;
  localparam logic [10:0] F_ID2  = 11'b1_10_01011010;
  localparam logic [10:0] F_ID3  = 11'b1_11_00111100;
  localparam logic [10:0] F_NONE = 11'b0_00_00000000;

  typedef struct {
    logic        rst_before;
    logic [3:0]  valid;
    logic        mosi0;
    int          nsck;
    logic [10:0] exp_bits;
    logic [3:0]  exp_ack;
  } row_t;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cycles;
  logic [3:0] ack_or;

  always @(negedge clk) begin
    if (req_ack != 4'b0000) begin
      ack_cycles = ack_cycles + 1;
      ack_or     = ack_or | req_ack;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(2);
  endtask

  task automatic run_row(input row_t r, input int tag);
    logic [10:0] bits;
    logic [10:0] mask;
    bits = '0;
    if (r.rst_before) do_reset();
    req_valid = r.valid;
    MOSI      = r.mosi0;
    wait_cycles(2);
    check($sformatf("row%0d idle_z", tag), 32'(MISO), 32'd1);
    ack_cycles = 0;
    ack_or     = 4'b0000;
    SSEL = 1'b0;
    wait_cycles(5);
    req_data = ~BASE_DATA;
    for (int i = 0; i < r.nsck; i++) begin
      bits[10-i] = MISO;
      SCK = 1'b1;
      wait_cycles(4);
      MOSI = 1'b0;
      SCK  = 1'b0;
      wait_cycles(4);
    end
    if (r.nsck == 11) check($sformatf("row%0d tail_zero", tag), 32'(MISO), 32'd0);
    SSEL = 1'b1;
    wait_cycles(6);
    req_data = BASE_DATA;
    check($sformatf("row%0d post_z", tag), 32'(MISO), 32'd1);
    mask = 11'h7FF << (11 - r.nsck);
    check($sformatf("row%0d miso_bits", tag), 32'(bits & mask), 32'(r.exp_bits & mask));
    check($sformatf("row%0d ack_vec", tag), 32'(ack_or), 32'(r.exp_ack));
    check($sformatf("row%0d ack_cycles", tag), 32'(ack_cycles), (r.exp_ack != 4'b0000) ? 32'd1 : 32'd0);
  endtask

  row_t rows[11];

  initial begin
    req_data   = BASE_DATA;
    ack_cycles = 0;
    ack_or     = 4'b0000;

    rows[0]  = '{1'b1, 4'b0010, 1'b1, 11, F_ID1,  4'b0010};
    rows[1]  = '{1'b1, 4'b1111, 1'b1, 11, F_ID0,  4'b0001};
    rows[2]  = '{1'b0, 4'b1111, 1'b1, 11, F_ID1,  4'b0010};
    rows[3]  = '{1'b0, 4'b1111, 1'b1, 11, F_ID2,  4'b0100};
    rows[4]  = '{1'b0, 4'b1111, 1'b1, 11, F_ID3,  4'b1000};
    rows[5]  = '{1'b0, 4'b1111, 1'b1, 11, F_ID0,  4'b0001};
    rows[6]  = '{1'b0, 4'b0100, 1'b0, 11, F_ID2,  4'b0000};
    rows[7]  = '{1'b0, 4'b0100, 1'b0, 11, F_ID2,  4'b0000};
    rows[8]  = '{1'b0, 4'b0001, 1'b1, 5,  F_ID0,  4'b0000};
    rows[9]  = '{1'b0, 4'b0001, 1'b1, 11, F_ID0,  4'b0001};
    rows[10] = '{1'b0, 4'b0000, 1'b1, 11, F_NONE, 4'b0000};

    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);
    check("reset miso_z", 32'(MISO), 32'd1);
    check("reset req_ack", 32'(req_ack), 32'd0);

    for (int i = 0; i < 11; i++) run_row(rows[i], i);

    // Reset while DATA is shifting: rr_ptr is 1 here, so a cleared pointer shows as id 0 below.
    req_valid  = 4'b1000;
    MOSI       = 1'b1;
    wait_cycles(2);
    ack_cycles = 0;
    ack_or     = 4'b0000;
    SSEL = 1'b0;
    wait_cycles(5);
    for (int i = 0; i < 4; i++) begin
      SCK = 1'b1;
      wait_cycles(4);
      MOSI = 1'b0;
      SCK  = 1'b0;
      wait_cycles(4);
    end
    check("midrst data_bit", 32'(MISO), 32'd0);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    check("midrst miso_z", 32'(MISO), 32'd1);
    wait_cycles(3);
    SSEL = 1'b1;
    wait_cycles(6);
    check("midrst no_ack", 32'(ack_cycles), 32'd0);
    check("midrst still_z", 32'(MISO), 32'd1);

    run_row('{1'b0, 4'b1111, 1'b0, 11, F_ID0, 4'b0000}, 20);
    run_row('{1'b0, 4'b1000, 1'b1, 11, F_ID3, 4'b1000}, 21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
